reorder_buffer: RTL and testbench

Circular reorder buffer sitting downstream of the issue stage.
- Allocates one entry per issued instruction at the tail and collects results from the ALU and LSB common data buses.
- Commits in order from the head: register write, store release, branch resolution.
- Publishes head/tail/empty so issue can compute free space.
- On a branch mispredict, flushes the whole speculative window.

---
 rtl/reorder_buffer_pkg.sv | 59 +++++
 rtl/reorder_buffer.sv | 191 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: default sizes, instruction id
// codes, the entry record and the head-instruction commit classifier.
package reorder_buffer_pkg;

    localparam int DEF_ROB_SIZE   = 16;
    localparam int DEF_ROB_IDX_W  = 4;
    localparam int DEF_INSTR_ID_W = 6;

    // Loads occupy ids 0..ID_LHU; ALU ops follow the branches.
    localparam logic [DEF_INSTR_ID_W-1:0] ID_LHU   = 6'd4;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_SB    = 6'd5;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_SW    = 6'd7;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_LUI   = 6'd8;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_AUIPC = 6'd9;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_JAL   = 6'd10;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_JALR  = 6'd11;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_BEQ   = 6'd12;
    localparam logic [DEF_INSTR_ID_W-1:0] ID_BGEU  = 6'd17;

    typedef enum logic [1:0] {
        CK_REG    = 2'd0,
        CK_STORE  = 2'd1,
        CK_BRANCH = 2'd2,
        CK_JALR   = 2'd3
    } commit_kind_e;

    typedef struct packed {
        logic                      busy;
        logic                      ready;
        logic [DEF_INSTR_ID_W-1:0] instr_id;
        logic [4:0]                rd;
        logic [31:0]               pc;
        logic                      pred_taken;
        logic [31:0]               val;
        logic                      taken;
        logic [31:0]               target;
    } rob_entry_t;

    function automatic commit_kind_e rob_commit_decode(input logic [DEF_INSTR_ID_W-1:0] instr_id);
        commit_kind_e kind;
        case (instr_id)
            ID_LUI, ID_AUIPC, ID_JAL: kind = CK_REG;
            ID_JALR:                  kind = CK_JALR;
            default: begin
                if (instr_id <= ID_LHU) begin
                    kind = CK_REG;
                end else if ((instr_id >= ID_SB) && (instr_id <= ID_SW)) begin
                    kind = CK_STORE;
                end else if ((instr_id >= ID_BEQ) && (instr_id <= ID_BGEU)) begin
                    kind = CK_BRANCH;
                end else begin
                    kind = CK_REG;
                end
            end
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail, collects ALU/LSB results,
// commits in order from the head and flushes the window on a mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE   = DEF_ROB_SIZE,
    parameter int ROB_IDX_W  = DEF_ROB_IDX_W,
    parameter int INSTR_ID_W = DEF_INSTR_ID_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_en_in,
    input  logic [INSTR_ID_W-1:0] issue_instr_id_in,
    input  logic [4:0]            issue_rd_in,
    input  logic [31:0]           issue_pc_in,
    input  logic                  issue_pred_taken_in,
    output logic                  rob_empty_out,
    output logic [ROB_IDX_W-1:0]  rob_head_out,
    output logic [ROB_IDX_W-1:0]  rob_tail_out,
    input  logic                  alu_cdb_en_in,
    input  logic [ROB_IDX_W-1:0]  alu_cdb_idx_in,
    input  logic [31:0]           alu_cdb_val_in,
    input  logic                  alu_cdb_taken_in,
    input  logic [31:0]           alu_cdb_target_in,
    input  logic                  lsb_cdb_en_in,
    input  logic [ROB_IDX_W-1:0]  lsb_cdb_idx_in,
    input  logic [31:0]           lsb_cdb_val_in,
    input  logic [ROB_IDX_W-1:0]  query1_idx_in,
    output logic                  query1_ready_out,
    output logic [31:0]           query1_val_out,
    input  logic [ROB_IDX_W-1:0]  query2_idx_in,
    output logic                  query2_ready_out,
    output logic [31:0]           query2_val_out,
    output logic                  commit_reg_en_out,
    output logic [4:0]            commit_rd_out,
    output logic [31:0]           commit_val_out,
    output logic [ROB_IDX_W-1:0]  commit_idx_out,
    output logic                  commit_store_en_out,
    output logic                  flush_out,
    output logic [31:0]           flush_pc_out
);

    localparam logic [ROB_IDX_W-1:0] IDX_ONE = {{(ROB_IDX_W-1){1'b0}}, 1'b1};

    rob_entry_t           entries_r [ROB_SIZE];
    logic [ROB_IDX_W-1:0] head_r;
    logic [ROB_IDX_W-1:0] tail_r;
    logic                 empty_r;

    rob_entry_t           head_e_s;
    commit_kind_e         kind_s;
    logic                 full_s;
    logic                 commit_s;
    logic                 writes_reg_s;
    logic                 mispredict_s;
    logic [31:0]          redirect_pc_s;
    logic                 issue_ok_s;
    logic [ROB_IDX_W-1:0] head_inc_s;
    logic [ROB_IDX_W-1:0] tail_inc_s;

    assign rob_empty_out = empty_r;
    assign rob_head_out  = head_r;
    assign rob_tail_out  = tail_r;

    // Head classification, commit/flush decision and allocation acceptance.
    always_comb begin
        head_e_s      = entries_r[head_r];
        kind_s        = rob_commit_decode(head_e_s.instr_id);
        full_s        = (head_r == tail_r) && !empty_r;
        commit_s      = rdy_in && head_e_s.busy && head_e_s.ready;
        writes_reg_s  = ((kind_s == CK_REG) || (kind_s == CK_JALR)) && (head_e_s.rd != 5'd0);
        head_inc_s    = head_r + IDX_ONE;
        tail_inc_s    = tail_r + IDX_ONE;
        if (kind_s == CK_JALR) begin
            mispredict_s = commit_s;
        end else if (kind_s == CK_BRANCH) begin
            mispredict_s = commit_s && (head_e_s.taken != head_e_s.pred_taken);
        end else begin
            mispredict_s = 1'b0;
        end
        // JALR always goes to its computed target; branches fall through when not taken.
        if ((kind_s == CK_JALR) || head_e_s.taken) begin
            redirect_pc_s = head_e_s.target;
        end else begin
            redirect_pc_s = head_e_s.pc + 32'd4;
        end
        // A full buffer can still accept when the head frees its slot this cycle.
        issue_ok_s = rdy_in && issue_en_in && (!full_s || commit_s) && !mispredict_s;
    end

    // Operand lookup with forwarding from results broadcast this cycle.
    always_comb begin
        query1_ready_out = entries_r[query1_idx_in].ready;
        query1_val_out   = entries_r[query1_idx_in].val;
        query2_ready_out = entries_r[query2_idx_in].ready;
        query2_val_out   = entries_r[query2_idx_in].val;
        if (alu_cdb_en_in && (alu_cdb_idx_in == query1_idx_in)) begin
            query1_ready_out = 1'b1;
            query1_val_out   = alu_cdb_val_in;
        end else if (lsb_cdb_en_in && (lsb_cdb_idx_in == query1_idx_in)) begin
            query1_ready_out = 1'b1;
            query1_val_out   = lsb_cdb_val_in;
        end else begin
            query1_ready_out = entries_r[query1_idx_in].ready;
        end
        if (alu_cdb_en_in && (alu_cdb_idx_in == query2_idx_in)) begin
            query2_ready_out = 1'b1;
            query2_val_out   = alu_cdb_val_in;
        end else if (lsb_cdb_en_in && (lsb_cdb_idx_in == query2_idx_in)) begin
            query2_ready_out = 1'b1;
            query2_val_out   = lsb_cdb_val_in;
        end else begin
            query2_ready_out = entries_r[query2_idx_in].ready;
        end
    end

    // Entry storage, pointers and registered commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_r[i] <= '0;
            end
            head_r              <= '0;
            tail_r              <= '0;
            empty_r             <= 1'b1;
            commit_reg_en_out   <= 1'b0;
            commit_rd_out       <= 5'd0;
            commit_val_out      <= 32'd0;
            commit_idx_out      <= '0;
            commit_store_en_out <= 1'b0;
            flush_out           <= 1'b0;
            flush_pc_out        <= 32'd0;
        end else if (!rdy_in) begin
            commit_reg_en_out   <= 1'b0;
            commit_store_en_out <= 1'b0;
            flush_out           <= 1'b0;
        end else begin
            commit_reg_en_out   <= commit_s && writes_reg_s;
            commit_store_en_out <= commit_s && (kind_s == CK_STORE);
            flush_out           <= mispredict_s;
            if (commit_s) begin
                commit_rd_out  <= head_e_s.rd;
                commit_val_out <= head_e_s.val;
                commit_idx_out <= head_r;
            end
            if (mispredict_s) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries_r[i] <= '0;
                end
                flush_pc_out <= redirect_pc_s;
                head_r       <= '0;
                tail_r       <= '0;
                empty_r      <= 1'b1;
            end else begin
                if (alu_cdb_en_in && entries_r[alu_cdb_idx_in].busy) begin
                    entries_r[alu_cdb_idx_in].ready  <= 1'b1;
                    entries_r[alu_cdb_idx_in].val    <= alu_cdb_val_in;
                    entries_r[alu_cdb_idx_in].taken  <= alu_cdb_taken_in;
                    entries_r[alu_cdb_idx_in].target <= alu_cdb_target_in;
                end
                if (lsb_cdb_en_in && entries_r[lsb_cdb_idx_in].busy) begin
                    entries_r[lsb_cdb_idx_in].ready <= 1'b1;
                    entries_r[lsb_cdb_idx_in].val   <= lsb_cdb_val_in;
                end
                if (commit_s) begin
                    entries_r[head_r].busy  <= 1'b0;
                    entries_r[head_r].ready <= 1'b0;
                    head_r                  <= head_inc_s;
                end
                // Written last so a full-buffer allocation overrides the freed head slot.
                if (issue_ok_s) begin
                    entries_r[tail_r] <= '{busy:       1'b1,
                                           ready:      1'b0,
                                           instr_id:   issue_instr_id_in,
                                           rd:         issue_rd_in,
                                           pc:         issue_pc_in,
                                           pred_taken: issue_pred_taken_in,
                                           val:        32'd0,
                                           taken:      1'b0,
                                           target:     32'd0};
                    tail_r  <= tail_inc_s;
                    empty_r <= 1'b0;
                end else if (commit_s && (head_inc_s == tail_r)) begin
                    empty_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand-written
// corner sequences and a randomized run against a window/count reference model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, issue_en, issue_pred;
    logic [5:0]  issue_id;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        empty;
    logic [3:0]  head, tail;
    logic        alu_en, alu_taken, lsb_en;
    logic [3:0]  alu_idx, lsb_idx, q1_idx, q2_idx;
    logic [31:0] alu_val, alu_tgt, lsb_val;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        c_reg_en, c_store_en, fl;
    logic [4:0]  c_rd;
    logic [31:0] c_val, fl_pc;
    logic [3:0]  c_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .issue_en_in(issue_en), .issue_instr_id_in(issue_id), .issue_rd_in(issue_rd),
        .issue_pc_in(issue_pc), .issue_pred_taken_in(issue_pred),
        .rob_empty_out(empty), .rob_head_out(head), .rob_tail_out(tail),
        .alu_cdb_en_in(alu_en), .alu_cdb_idx_in(alu_idx), .alu_cdb_val_in(alu_val),
        .alu_cdb_taken_in(alu_taken), .alu_cdb_target_in(alu_tgt),
        .lsb_cdb_en_in(lsb_en), .lsb_cdb_idx_in(lsb_idx), .lsb_cdb_val_in(lsb_val),
        .query1_idx_in(q1_idx), .query1_ready_out(q1_ready), .query1_val_out(q1_val),
        .query2_idx_in(q2_idx), .query2_ready_out(q2_ready), .query2_val_out(q2_val),
        .commit_reg_en_out(c_reg_en), .commit_rd_out(c_rd), .commit_val_out(c_val),
        .commit_idx_out(c_idx), .commit_store_en_out(c_store_en),
        .flush_out(fl), .flush_pc_out(fl_pc)
    );

    typedef struct {
        logic ie; logic [5:0] id; logic [4:0] rd; logic [31:0] pc; logic pred;
        logic ae; logic [3:0] aidx; logic [31:0] aval; logic atk; logic [31:0] atgt;
        logic e_empty; logic [3:0] e_head; logic [3:0] e_tail;
        logic e_reg; logic [4:0] e_rd; logic [31:0] e_val; logic e_fl; logic [31:0] e_fpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ie, input logic [5:0] id, input logic [4:0] rd,
                                input logic [31:0] pc, input logic pred, input logic ae,
                                input logic [3:0] aidx, input logic [31:0] aval, input logic atk,
                                input logic [31:0] atgt, input logic e_empty, input logic [3:0] e_head,
                                input logic [3:0] e_tail, input logic e_reg, input logic [4:0] e_rd,
                                input logic [31:0] e_val, input logic e_fl, input logic [31:0] e_fpc);
        vec_t v;
        v = '{ie, id, rd, pc, pred, ae, aidx, aval, atk, atgt,
              e_empty, e_head, e_tail, e_reg, e_rd, e_val, e_fl, e_fpc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_en = 1'b0; issue_id = 6'd0; issue_rd = 5'd0; issue_pc = 32'd0; issue_pred = 1'b0;
        alu_en = 1'b0; alu_idx = 4'd0; alu_val = 32'd0; alu_taken = 1'b0; alu_tgt = 32'd0;
        lsb_en = 1'b0; lsb_idx = 4'd0; lsb_val = 32'd0; q1_idx = 4'd0; q2_idx = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [5:0] id, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
        issue_en = 1'b1; issue_id = id; issue_rd = rd; issue_pc = pc; issue_pred = pred;
    endtask

    // Reference model: ring of entries described by head position and live count.
    int          m_head, m_count;
    logic        m_rdy [16];
    logic [5:0]  m_id  [16];
    logic [4:0]  m_rd  [16];
    logic [31:0] m_pc  [16];
    logic        m_pred[16];
    logic [31:0] m_val [16];
    logic        m_tk  [16];
    logic [31:0] m_tgt [16];

    function automatic bit in_window(input int idx);
        return ((idx - m_head + 16) % 16) < m_count;
    endfunction

    function automatic logic [5:0] rand_id();
        int r;
        r = $urandom_range(0, 59);
        if (r < 30)      return 6'(18 + $urandom_range(0, 19));
        else if (r < 39) return 6'($urandom_range(0, 4));
        else if (r < 48) return 6'($urandom_range(5, 7));
        else if (r < 54) return 6'($urandom_range(12, 17));
        else if (r < 56) return 6'd10;
        else if (r < 58) return 6'($urandom_range(8, 9));
        else             return 6'd11;
    endfunction

    initial begin
        int   alu_c[$];
        int   lsb_c[$];
        int   h, idx;
        logic commit, is_store, is_branch, is_jalr, e_reg, e_store, e_fl;
        logic [31:0] e_fpc, e_val;
        logic [4:0]  e_rd;
        logic [3:0]  e_idx;
        logic        e_q;
        logic [31:0] e_qv;

        do_reset();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_head", 32'(head), 32'd0);
        chk("reset_tail", 32'(tail), 32'd0);
        chk("reset_reg_en", 32'(c_reg_en), 32'd0);
        chk("reset_store_en", 32'(c_store_en), 32'd0);
        chk("reset_flush", 32'(fl), 32'd0);
        chk("reset_flush_pc", fl_pc, 32'd0);
        chk("reset_commit_val", c_val, 32'd0);

        // Directed vector table (ids: 18 ADDI, 12 BEQ, 13 BNE, 11 JALR).
        tbl.push_back(mk(1, 18, 5, 32'h0,   0, 0, 0, 0,      0, 0,      0, 0, 1, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 1, 0, 7,      0, 0,      0, 0, 1, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 0, 0, 0,      0, 0,      1, 1, 1, 1, 5,  7,      0, 0));
        tbl.push_back(mk(1, 12, 0, 32'h100, 0, 0, 0, 0,      0, 0,      0, 1, 2, 0, 0,  0,      0, 0));
        tbl.push_back(mk(1, 18, 1, 32'h104, 0, 0, 0, 0,      0, 0,      0, 1, 3, 0, 0,  0,      0, 0));
        tbl.push_back(mk(1, 18, 2, 32'h108, 0, 0, 0, 0,      0, 0,      0, 1, 4, 0, 0,  0,      0, 0));
        tbl.push_back(mk(1, 18, 3, 32'h10c, 0, 1, 1, 0,      1, 32'h200, 0, 1, 5, 0, 0, 0,      0, 0));
        tbl.push_back(mk(1, 18, 4, 32'h110, 0, 0, 0, 0,      0, 0,      1, 0, 0, 0, 0,  0,      1, 32'h200));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 0, 0, 0,      0, 0,      1, 0, 0, 0, 0,  0,      0, 0));
        tbl.push_back(mk(1, 18, 10, 32'h10, 0, 0, 0, 0,      0, 0,      0, 0, 1, 0, 0,  0,      0, 0));
        tbl.push_back(mk(1, 18, 11, 32'h14, 0, 0, 0, 0,      0, 0,      0, 0, 2, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 1, 1, 32'h11, 0, 0,      0, 0, 2, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 0, 0, 0,      0, 0,      0, 0, 2, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 1, 0, 32'h10, 0, 0,      0, 0, 2, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 0, 0, 0,      0, 0,      0, 1, 2, 1, 10, 32'h10, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 0, 0, 0,      0, 0,      1, 2, 2, 1, 11, 32'h11, 0, 0));
        tbl.push_back(mk(1, 13, 0, 32'h40,  1, 0, 0, 0,      0, 0,      0, 2, 3, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 1, 2, 0,      0, 32'h80, 0, 2, 3, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 0, 0, 0,      0, 0,      1, 0, 0, 0, 0,  0,      1, 32'h44));
        tbl.push_back(mk(1, 11, 1, 32'h300, 0, 0, 0, 0,      0, 0,      0, 0, 1, 0, 0,  0,      0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 1, 0, 32'h304, 1, 32'h500, 0, 0, 1, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,   0, 0, 0, 0,      0, 0,      1, 0, 0, 1, 1,  32'h304, 1, 32'h500));

        foreach (tbl[i]) begin
            idle_inputs();
            issue_en = tbl[i].ie; issue_id = tbl[i].id; issue_rd = tbl[i].rd;
            issue_pc = tbl[i].pc; issue_pred = tbl[i].pred;
            alu_en = tbl[i].ae; alu_idx = tbl[i].aidx; alu_val = tbl[i].aval;
            alu_taken = tbl[i].atk; alu_tgt = tbl[i].atgt;
            step();
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("vec%0d_head", i), 32'(head), 32'(tbl[i].e_head));
            chk($sformatf("vec%0d_tail", i), 32'(tail), 32'(tbl[i].e_tail));
            chk($sformatf("vec%0d_reg_en", i), 32'(c_reg_en), 32'(tbl[i].e_reg));
            chk($sformatf("vec%0d_flush", i), 32'(fl), 32'(tbl[i].e_fl));
            if (tbl[i].e_reg) begin
                chk($sformatf("vec%0d_rd", i), 32'(c_rd), 32'(tbl[i].e_rd));
                chk($sformatf("vec%0d_val", i), c_val, tbl[i].e_val);
            end
            if (tbl[i].e_fl) chk($sformatf("vec%0d_flush_pc", i), fl_pc, tbl[i].e_fpc);
        end

        // Fill to full, overflow attempt, freeze, then simultaneous commit+issue.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            issue(6'd18, 5'((i + 1) % 16), 32'(i * 4), 1'b0);
            step();
            if (i == 0) chk("fill_first_empty", 32'(empty), 32'd0);
        end
        chk("full_head", 32'(head), 32'd0);
        chk("full_tail", 32'(tail), 32'd0);
        chk("full_empty", 32'(empty), 32'd0);
        idle_inputs();
        issue(6'd18, 5'd9, 32'h80, 1'b0);
        step();
        chk("full_ignored_tail", 32'(tail), 32'd0);
        chk("full_ignored_empty", 32'(empty), 32'd0);
        idle_inputs();
        alu_en = 1'b1; alu_idx = 4'd0; alu_val = 32'hAA;
        step();
        idle_inputs();
        rdy = 1'b0;
        issue(6'd18, 5'd7, 32'h84, 1'b0);
        step();
        chk("frozen_head", 32'(head), 32'd0);
        chk("frozen_tail", 32'(tail), 32'd0);
        chk("frozen_reg_en", 32'(c_reg_en), 32'd0);
        rdy = 1'b1;
        step();
        chk("full_commit_reg_en", 32'(c_reg_en), 32'd1);
        chk("full_commit_rd", 32'(c_rd), 32'd1);
        chk("full_commit_val", c_val, 32'hAA);
        chk("full_commit_head", 32'(head), 32'd1);
        chk("full_commit_tail", 32'(tail), 32'd1);
        chk("full_commit_empty", 32'(empty), 32'd0);
        idle_inputs();
        step();
        chk("commit_pulse_ends", 32'(c_reg_en), 32'd0);

        // Query forwarding from both CDBs, then from the stored entry.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            issue(6'd18, 5'(i + 1), 32'(i * 4), 1'b0);
            step();
        end
        idle_inputs();
        lsb_en = 1'b1; lsb_idx = 4'd2; lsb_val = 32'hDEAD;
        alu_en = 1'b1; alu_idx = 4'd1; alu_val = 32'h1234;
        q1_idx = 4'd2; q2_idx = 4'd0;
        #1;
        chk("fwd_lsb_ready", 32'(q1_ready), 32'd1);
        chk("fwd_lsb_val", q1_val, 32'hDEAD);
        chk("unready_query", 32'(q2_ready), 32'd0);
        q2_idx = 4'd1;
        #1;
        chk("fwd_alu_ready", 32'(q2_ready), 32'd1);
        chk("fwd_alu_val", q2_val, 32'h1234);
        step();
        idle_inputs();
        q2_idx = 4'd2;
        #1;
        chk("stored_query_ready", 32'(q2_ready), 32'd1);
        chk("stored_query_val", q2_val, 32'hDEAD);

        // Reset asserted mid-operation with competing issue and CDB activity.
        rst = 1'b1;
        issue(6'd18, 5'd4, 32'h40, 1'b0);
        alu_en = 1'b1; alu_idx = 4'd0; alu_val = 32'h5;
        step();
        chk("midrst_head", 32'(head), 32'd0);
        chk("midrst_tail", 32'(tail), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_reg_en", 32'(c_reg_en), 32'd0);
        rst = 1'b0;

        // Randomized run against the reference model.
        do_reset();
        m_head = 0; m_count = 0;
        for (int i = 0; i < 16; i++) m_rdy[i] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle_inputs();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) != 0)
                issue(rand_id(), 5'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            alu_c.delete();
            lsb_c.delete();
            for (int k = 0; k < m_count; k++) begin
                idx = (m_head + k) % 16;
                if (!m_rdy[idx]) begin
                    if (m_id[idx] <= 6'd7) lsb_c.push_back(idx);
                    else alu_c.push_back(idx);
                end
            end
            if ((alu_c.size() > 0) && ($urandom_range(0, 3) != 0)) begin
                alu_en = 1'b1; alu_idx = 4'(alu_c[$urandom_range(0, alu_c.size() - 1)]);
                alu_val = $urandom; alu_taken = 1'($urandom_range(0, 1)); alu_tgt = $urandom & 32'hFFFF_FFFC;
            end
            if ((lsb_c.size() > 0) && ($urandom_range(0, 3) != 0)) begin
                lsb_en = 1'b1; lsb_idx = 4'(lsb_c[$urandom_range(0, lsb_c.size() - 1)]); lsb_val = $urandom;
            end
            q1_idx = 4'($urandom_range(0, 15));
            q2_idx = 4'($urandom_range(0, 15));
            #1;
            e_q = (alu_en && alu_idx == q1_idx) || (lsb_en && lsb_idx == q1_idx) || (in_window(int'(q1_idx)) && m_rdy[q1_idx]);
            e_qv = (alu_en && alu_idx == q1_idx) ? alu_val : (lsb_en && lsb_idx == q1_idx) ? lsb_val : m_val[q1_idx];
            chk("rnd_q1_ready", 32'(q1_ready), 32'(e_q));
            if (e_q) chk("rnd_q1_val", q1_val, e_qv);
            e_q = (alu_en && alu_idx == q2_idx) || (lsb_en && lsb_idx == q2_idx) || (in_window(int'(q2_idx)) && m_rdy[q2_idx]);
            e_qv = (alu_en && alu_idx == q2_idx) ? alu_val : (lsb_en && lsb_idx == q2_idx) ? lsb_val : m_val[q2_idx];
            chk("rnd_q2_ready", 32'(q2_ready), 32'(e_q));
            if (e_q) chk("rnd_q2_val", q2_val, e_qv);

            h = m_head;
            commit = rdy && (m_count > 0) && m_rdy[h];
            is_store  = (m_id[h] >= 6'd5) && (m_id[h] <= 6'd7);
            is_branch = (m_id[h] >= 6'd12) && (m_id[h] <= 6'd17);
            is_jalr   = (m_id[h] == 6'd11);
            e_reg   = commit && !is_store && !is_branch && (m_rd[h] != 5'd0);
            e_store = commit && is_store;
            e_fl    = commit && (is_jalr || (is_branch && (m_tk[h] != m_pred[h])));
            e_fpc   = (is_jalr || m_tk[h]) ? m_tgt[h] : m_pc[h] + 32'd4;
            e_rd = m_rd[h]; e_val = m_val[h]; e_idx = 4'(h);
            if (rdy) begin
                if (alu_en) begin
                    m_rdy[alu_idx] = 1'b1; m_val[alu_idx] = alu_val; m_tk[alu_idx] = alu_taken; m_tgt[alu_idx] = alu_tgt;
                end
                if (lsb_en) begin
                    m_rdy[lsb_idx] = 1'b1; m_val[lsb_idx] = lsb_val;
                end
                if (e_fl) begin
                    m_head = 0; m_count = 0;
                end else begin
                    if (commit) begin
                        m_rdy[h] = 1'b0; m_head = (m_head + 1) % 16; m_count--;
                    end
                    if (issue_en && m_count < 16) begin
                        idx = (m_head + m_count) % 16;
                        m_rdy[idx] = 1'b0; m_id[idx] = issue_id; m_rd[idx] = issue_rd;
                        m_pc[idx] = issue_pc; m_pred[idx] = issue_pred; m_count++;
                    end
                end
            end
            step();
            chk("rnd_head", 32'(head), 32'(m_head));
            chk("rnd_tail", 32'(tail), 32'((m_head + m_count) % 16));
            chk("rnd_empty", 32'(empty), 32'(m_count == 0));
            chk("rnd_reg_en", 32'(c_reg_en), 32'(e_reg));
            chk("rnd_store_en", 32'(c_store_en), 32'(e_store));
            chk("rnd_flush", 32'(fl), 32'(e_fl));
            if (e_reg) begin
                chk("rnd_commit_rd", 32'(c_rd), 32'(e_rd));
                chk("rnd_commit_val", c_val, e_val);
                chk("rnd_commit_idx", 32'(c_idx), 32'(e_idx));
            end
            if (e_fl) chk("rnd_flush_pc", fl_pc, e_fpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
